ram_unit: RTL and testbench

- Single-port, word-addressed 32-bit data RAM for the RISC-V 32I CPU datapath, with region-checked addressing.
- An 11-bit address splits into a 3-bit region tag and an 8-bit word index.
- Only the configured region (3'b100) is backed by storage. Any other region raises seg_fault, and the access has no effect.

---
 rtl/ram_unit_if.sv | 30 +++
 rtl/ram_unit.sv | 72 +++++++
 tb/tb_ram_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ram_unit_if.sv
// ram_unit_if: access bus of the region-checked data RAM (address, write data,
// write strobe in; registered read data and segmentation flag out).
interface ram_unit_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              write_en;
    logic [DATA_W-1:0] dout;
    logic              seg_fault;

    // Requester side: drives the access, observes the result
    modport master (
        output addr,
        output din,
        output write_en,
        input  dout,
        input  seg_fault
    );

    // RAM side: samples the access, returns the result
    modport slave (
        input  addr,
        input  din,
        input  write_en,
        output dout,
        output seg_fault
    );
endinterface

// File: rtl/ram_unit.sv
// ram_unit: single-port, word-addressed data RAM for the RV32I datapath.
// The upper address bits form a region tag; only REGION is backed by storage,
// any other tag flags seg_fault and leaves memory untouched.
// Optional build macro RAM_RESET_CLEAR_EN: a reset cycle also zeroes every word.
module ram_unit #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned DATA_W  = 32,
    parameter logic [ADDR_W-INDEX_W-1:0] REGION = 3'b100
) (
    input  logic      clk,
    input  logic      rst,
    ram_unit_if.slave bus
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W;
    localparam int unsigned DEPTH = 2 ** INDEX_W;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_index;
    logic               w_hit;
    logic               w_wr_hit;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_dout;
    logic               r_seg_fault;

    // Address decode: region tag selects this RAM, index selects the word
    assign w_tag    = bus.addr[ADDR_W-1:INDEX_W];
    assign w_index  = bus.addr[INDEX_W-1:0];
    assign w_hit    = (w_tag == REGION);
    assign w_wr_hit = w_hit && bus.write_en;

`ifdef RAM_RESET_CLEAR_EN
    // Storage update: reset wipes the array, otherwise write on a hit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_mem[w_index] <= bus.din;
        end
    end
`else
    // Storage update: write on a hit; reset leaves contents so the array can map to block RAM
    always_ff @(posedge clk) begin
        if (!rst && w_wr_hit) begin
            r_mem[w_index] <= bus.din;
        end
    end
`endif

    // Result registers: write-through data on writes, zero and fault on a miss
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout      <= '0;
            r_seg_fault <= 1'b0;
        end else if (!w_hit) begin
            r_dout      <= '0;
            r_seg_fault <= 1'b1;
        end else if (bus.write_en) begin
            r_dout      <= bus.din;
            r_seg_fault <= 1'b0;
        end else begin
            r_dout      <= r_mem[w_index];
            r_seg_fault <= 1'b0;
        end
    end

    assign bus.dout      = r_dout;
    assign bus.seg_fault = r_seg_fault;
endmodule

// File: tb/tb_ram_unit.sv
// tb_ram_unit: directed self-checking bench for ram_unit (hit/miss, bulk fill,
// reset behaviour with and without RAM_RESET_CLEAR_EN).
module tb_ram_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ram_unit_if u_bus ();

    ram_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one access at the falling edge, sample just after the next rising edge
    task automatic do_cycle(input logic r, input logic [10:0] a, input logic [31:0] d, input logic we);
        @(negedge clk);
        rst            = r;
        u_bus.addr     = a;
        u_bus.din      = d;
        u_bus.write_en = we;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_after_rst;
    logic [31:0] exp_idx0_after_rst;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        u_bus.addr     = '0;
        u_bus.din      = '0;
        u_bus.write_en = 1'b0;

        // Reset
        do_cycle(1'b1, 11'b000_00000000, 32'h0, 1'b0);
        check_eq("rst_dout", u_bus.dout, 32'h0);
        check_eq("rst_seg", 32'(u_bus.seg_fault), 32'h0);

        // Write then read hit
        do_cycle(1'b0, 11'b100_00000101, 32'd5, 1'b1);
        check_eq("wr_dout", u_bus.dout, 32'd5);
        check_eq("wr_seg", 32'(u_bus.seg_fault), 32'h0);
        do_cycle(1'b0, 11'b100_00000101, 32'h0, 1'b0);
        check_eq("rd_dout", u_bus.dout, 32'd5);
        check_eq("rd_seg", 32'(u_bus.seg_fault), 32'h0);

        // Bulk fill and read-back
        for (int i = 0; i < 256; i++) begin
            do_cycle(1'b0, {3'b100, 8'(i)}, 32'hDEAD0000 + 32'(i), 1'b1);
            check_eq("bulk_wr", u_bus.dout, 32'hDEAD0000 + 32'(i));
        end
        for (int i = 0; i < 256; i++) begin
            do_cycle(1'b0, {3'b100, 8'(i)}, 32'h0, 1'b0);
            check_eq("bulk_rd", u_bus.dout, 32'hDEAD0000 + 32'(i));
            check_eq("bulk_seg", 32'(u_bus.seg_fault), 32'h0);
        end

        // Restore index 5 to 5
        do_cycle(1'b0, 11'b100_00000101, 32'd5, 1'b1);
        check_eq("restore5", u_bus.dout, 32'd5);

        // Miss write has no effect on memory
        do_cycle(1'b0, 11'b011_00000101, 32'hFFFFFFFF, 1'b1);
        check_eq("misswr_seg", 32'(u_bus.seg_fault), 32'h1);
        check_eq("misswr_dout", u_bus.dout, 32'h0);
        do_cycle(1'b0, 11'b100_00000101, 32'h0, 1'b0);
        check_eq("after_miss_dout", u_bus.dout, 32'd5);
        check_eq("after_miss_seg", 32'(u_bus.seg_fault), 32'h0);

        // Miss read then hit read
        do_cycle(1'b0, 11'b111_11111111, 32'h0, 1'b0);
        check_eq("missrd_seg", 32'(u_bus.seg_fault), 32'h1);
        check_eq("missrd_dout", u_bus.dout, 32'h0);
        do_cycle(1'b0, 11'b100_00000000, 32'h0, 1'b0);
        check_eq("hit0_seg", 32'(u_bus.seg_fault), 32'h0);
        check_eq("hit0_dout", u_bus.dout, 32'hDEAD0000);

        // Region 000 is also unmapped
        do_cycle(1'b0, 11'b000_00000000, 32'h0, 1'b0);
        check_eq("miss000_seg", 32'(u_bus.seg_fault), 32'h1);

        // Reset mid-operation with a pending write
        do_cycle(1'b1, 11'b100_00000101, 32'd9, 1'b1);
        check_eq("midrst_dout", u_bus.dout, 32'h0);
        check_eq("midrst_seg", 32'(u_bus.seg_fault), 32'h0);

`ifdef RAM_RESET_CLEAR_EN
        exp_after_rst      = 32'h0;
        exp_idx0_after_rst = 32'h0;
`else
        exp_after_rst      = 32'd5;
        exp_idx0_after_rst = 32'hDEAD0000;
`endif
        do_cycle(1'b0, 11'b100_00000101, 32'h0, 1'b0);
        check_eq("postrst_idx5", u_bus.dout, exp_after_rst);
        check_eq("postrst_seg", 32'(u_bus.seg_fault), 32'h0);
        do_cycle(1'b0, 11'b100_00000000, 32'h0, 1'b0);
        check_eq("postrst_idx0", u_bus.dout, exp_idx0_after_rst);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
